// File: rtl/seg_add_sequencer_pkg.sv
// Shared types and defaults for the segmented multi-cycle adder.
package seg_add_sequencer_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SEG   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Segment index width: clog2 of the segment count, never narrower than 1 bit.
   function automatic int idx_width(input int n_seg);
      return (n_seg > 1) ? $clog2(n_seg) : 1;
   endfunction

endpackage

// File: rtl/seg_rca.sv
// Combinational SEG-bit ripple-carry adder built from a chain of full-adder cells.
module seg_rca
   import seg_add_sequencer_pkg::*;
#(
   parameter int SEG = DEF_SEG
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   logic [SEG:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < SEG; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[SEG];

endmodule

// File: rtl/seg_add_sequencer.sv
// Multi-cycle adder: captures an operand pair, adds one SEG-bit segment per cycle
// through a single ripple-carry adder, then holds the result until it is taken.
module seg_add_sequencer
   import seg_add_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int N  = WIDTH / SEG;
   localparam int IW = idx_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   if ((WIDTH % SEG) != 0) begin : g_seg_check
      $error("seg_add_sequencer: WIDTH must be a multiple of SEG");
   end

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [SEG-1:0]   seg_a, seg_b, seg_sum;
   logic             seg_cout;

   assign seg_a = a_q[idx_q*SEG +: SEG];
   assign seg_b = b_q[idx_q*SEG +: SEG];

   seg_rca #(.SEG(SEG)) u_rca (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (carry_q),
      .sum  (seg_sum),
      .cout (seg_cout)
   );

   // NOTE: every signal gets its hold value first, so no branch can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[idx_q*SEG +: SEG] = seg_sum;
            carry_d                 = seg_cout;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values,
   // independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
      end
   end

   // NOTE: operand registers are always loaded before they are read, so they
   // carry no reset and stay plain data flops.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_sum   = sum_q;
   assign out_cout  = carry_q;

endmodule

// File: tb/tb_seg_add_sequencer.sv
// Self-checking bench for seg_add_sequencer at default WIDTH=64, SEG=16.
module tb_seg_add_sequencer;

   localparam int WIDTH   = 64;
   localparam int SEG     = 16;
   localparam int LATENCY = WIDTH / SEG;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seg_add_sequencer #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one operand pair, scrambles the inputs right after the accept edge,
   // and counts rising edges until out_valid (bounded).
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        output logic [WIDTH-1:0] s, output logic c, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = {$urandom, $urandom};
      in_b     = ~b;
      in_cin   = ~cin;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      s = out_sum;
      c = out_cout;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] s, held;
      logic             c;
      logic [WIDTH:0]   ref_full;
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      logic             seen_valid;
      int               lat;

      vecs[0] = '{"basic",      64'h1, 64'h2, 1'b0, 64'h3, 1'b0};
      vecs[1] = '{"full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
      vecs[2] = '{"seg_carry",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
      vecs[3] = '{"zero",       64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
      vecs[4] = '{"ones_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[5] = '{"msb_wrap",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
      vecs[6] = '{"alt_bits",   64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1};
      vecs[7] = '{"two_bounds", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                  64'h0001_0000_0001_0000, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready",  64'(in_ready),  64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_sum",   out_sum,        64'd0);
      check("reset_out_cout",  64'(out_cout),  64'd0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
         check({vecs[i].name, "_latency"},  64'(lat),       64'(LATENCY));
         check({vecs[i].name, "_sum"},      s,              vecs[i].sum);
         check({vecs[i].name, "_cout"},     64'(c),         64'(vecs[i].cout));
         check({vecs[i].name, "_busy"},     64'(in_ready),  64'd0);
         release_out();
         check({vecs[i].name, "_to_idle"},  64'(in_ready),  64'd1);
         check({vecs[i].name, "_valid_lo"}, 64'(out_valid), 64'd0);
      end

      // Backpressure: result must hold for 10 cycles while out_ready stays low.
      do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, s, c, lat);
      check("bp_latency", 64'(lat), 64'(LATENCY));
      check("bp_sum",     s,        64'h2345_6789_ABCD_F001);
      held = out_sum;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("bp_hold_sum",   out_sum,        held);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_busy",  64'(in_ready),  64'd0);
      end
      release_out();
      check("bp_release_idle", 64'(in_ready), 64'd1);

      // Reset applied while segment 2 is being processed.
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
      in_b     = 64'h1;
      in_cin   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrun_rst_ready", 64'(in_ready), 64'd1);
      check("midrun_rst_sum",   out_sum,       64'd0);
      check("midrun_rst_cout",  64'(out_cout), 64'd0);
      seen_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         seen_valid |= out_valid;
      end
      check("midrun_no_valid", 64'(seen_valid), 64'd0);

      // Reset wins over a simultaneous accept.
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_a     = 64'h5;
      in_b     = 64'h7;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_prio_ready", 64'(in_ready), 64'd1);
      seen_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         seen_valid |= out_valid;
      end
      check("rst_prio_no_valid", 64'(seen_valid), 64'd0);

      // Reset while holding a result in DONE.
      do_op(64'h10, 64'h20, 1'b1, s, c, lat);
      check("done_rst_sum_pre", s, 64'h31);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("done_rst_valid", 64'(out_valid), 64'd0);
      check("done_rst_sum",   out_sum,        64'd0);
      check("done_rst_ready", 64'(in_ready),  64'd1);

      // Back-to-back random operations against an arithmetic reference.
      for (int k = 0; k < 1000; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         ref_full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
         do_op(ra, rb, rc, s, c, lat);
         check("rand_latency", 64'(lat), 64'(LATENCY));
         check("rand_sum",     s,        ref_full[WIDTH-1:0]);
         check("rand_cout",    64'(c),   64'(ref_full[WIDTH]));
         release_out();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
